// File: rtl/multi_input_conditioner_pkg.sv
`default_nettype none
// =====================================================================
// multi_input_conditioner_pkg : shared types/helpers for the conditioner
// Rev 1.0
// =====================================================================
package multi_input_conditioner_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Debounce counter width: must hold values 0..WAITTIME.
  function automatic int calc_cw(input int waittime);
    return (waittime < 1) ? 1 : $clog2(waittime + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_input_conditioner_chan.sv
`default_nettype none
// =====================================================================
// input_conditioner_chan : one channel - synchroniser, debounce, edges
// Optional sticky flags under MULTI_INPUT_CONDITIONER_STICKY_EN. Rev 1.0
// =====================================================================
module input_conditioner_chan
  import multi_input_conditioner_pkg::*;
#(
  parameter int SYNCSTAGES = 2,
  parameter int WAITTIME   = 3,
  parameter bit RESETVAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic noisy_i,
  input  logic stickyclear_i,
  output logic conditioned_o,
  output logic pos_pulse_o,
  output logic neg_pulse_o,
  output logic stickyrise_o,
  output logic stickyfall_o
);

  localparam int            CW       = calc_cw(WAITTIME);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAITTIME - 1);

  logic [SYNCSTAGES-1:0] sync_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cond_q, cond_d;
  edge_e                 edge_q, edge_d;
  logic                  s;

  assign s = sync_q[SYNCSTAGES-1];

  // Any sample agreeing with the current level discards accumulated progress.
  always_comb begin
    cnt_d  = '0;
    cond_d = cond_q;
    edge_d = EDGE_NONE;
    if (s != cond_q) begin
      if (cnt_q == CNT_LAST) begin
        cond_d = s;
        edge_d = s ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNCSTAGES{RESETVAL}};
      cnt_q  <= '0;
      cond_q <= RESETVAL;
      edge_q <= EDGE_NONE;
    end else begin
      sync_q <= {sync_q[SYNCSTAGES-2:0], noisy_i};
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
      edge_q <= edge_d;
    end
  end

  assign conditioned_o = cond_q;
  assign pos_pulse_o   = (edge_q == EDGE_RISE);
  assign neg_pulse_o   = (edge_q == EDGE_FALL);

`ifdef MULTI_INPUT_CONDITIONER_STICKY_EN
  logic srise_q, sfall_q;

  // A pulse arriving on the clearing edge still sets the flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      srise_q <= 1'b0;
      sfall_q <= 1'b0;
    end else begin
      srise_q <= (srise_q & ~stickyclear_i) | pos_pulse_o;
      sfall_q <= (sfall_q & ~stickyclear_i) | neg_pulse_o;
    end
  end

  assign stickyrise_o = srise_q;
  assign stickyfall_o = sfall_q;
`else
  logic unused_stickyclear;
  assign unused_stickyclear = stickyclear_i;
  assign stickyrise_o       = 1'b0;
  assign stickyfall_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/multi_input_conditioner.sv
`default_nettype none
// =====================================================================
// multi_input_conditioner : N-channel sync/debounce/edge-pulse front end
// Optional sticky flags under MULTI_INPUT_CONDITIONER_STICKY_EN. Rev 1.0
// =====================================================================
module multi_input_conditioner
  import multi_input_conditioner_pkg::*;
#(
  parameter int NCHAN      = 4,
  parameter int SYNCSTAGES = 2,
  parameter int WAITTIME   = 3,
  parameter bit RESETVAL   = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NCHAN-1:0] noisysignal,
  output logic [NCHAN-1:0] conditioned,
  output logic [NCHAN-1:0] positiveedge,
  output logic [NCHAN-1:0] negativeedge,
  output logic             anychange,
  output logic [NCHAN-1:0] stickyrise,
  output logic [NCHAN-1:0] stickyfall,
  input  logic [NCHAN-1:0] stickyclear
);

  logic anychange_q;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    input_conditioner_chan #(
      .SYNCSTAGES (SYNCSTAGES),
      .WAITTIME   (WAITTIME),
      .RESETVAL   (RESETVAL)
    ) u_chan (
      .clk_i         (clk),
      .rst_ni        (resetn),
      .noisy_i       (noisysignal[i]),
      .stickyclear_i (stickyclear[i]),
      .conditioned_o (conditioned[i]),
      .pos_pulse_o   (positiveedge[i]),
      .neg_pulse_o   (negativeedge[i]),
      .stickyrise_o  (stickyrise[i]),
      .stickyfall_o  (stickyfall[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) anychange_q <= 1'b0;
    else         anychange_q <= |(positiveedge | negativeedge);
  end

  assign anychange = anychange_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_input_conditioner.sv
`default_nettype none
// =====================================================================
// tb_multi_input_conditioner : randomized + directed bench with a
// window-based reference model for three parameterisations. Rev 1.0
// =====================================================================
module tb_multi_input_conditioner;

`ifdef MULTI_INPUT_CONDITIONER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] nz0 = '0, clr0 = '0, c0, p0, n0, sr0, sf0;
  logic [0:0] nz1 = '0, clr1 = '0, c1, p1, n1, sr1, sf1;
  logic [7:0] nz2 = '0, clr2 = '0, c2, p2, n2, sr2, sf2;
  logic       a0, a1, a2;

  int total = 0;
  int bad   = 0;

  multi_input_conditioner u_dut (
    .clk(clk), .resetn(resetn), .noisysignal(nz0), .conditioned(c0),
    .positiveedge(p0), .negativeedge(n0), .anychange(a0),
    .stickyrise(sr0), .stickyfall(sf0), .stickyclear(clr0));

  multi_input_conditioner #(.NCHAN(1), .SYNCSTAGES(3), .WAITTIME(1), .RESETVAL(1'b0)) u_a (
    .clk(clk), .resetn(resetn), .noisysignal(nz1), .conditioned(c1),
    .positiveedge(p1), .negativeedge(n1), .anychange(a1),
    .stickyrise(sr1), .stickyfall(sf1), .stickyclear(clr1));

  multi_input_conditioner #(.NCHAN(8), .SYNCSTAGES(2), .WAITTIME(7), .RESETVAL(1'b0)) u_b (
    .clk(clk), .resetn(resetn), .noisysignal(nz2), .conditioned(c2),
    .positiveedge(p2), .negativeedge(n2), .anychange(a2),
    .stickyrise(sr2), .stickyfall(sf2), .stickyclear(clr2));

  // Reference model: a level is accepted once the last WAITTIME synchronised
  // samples (input delayed by SYNCSTAGES edges) all disagree with it.
  int S_P [3] = '{2, 3, 2};
  int W_P [3] = '{3, 1, 7};
  int N_P [3] = '{4, 1, 8};

  logic [7:0] hist [3][16];
  logic [7:0] m_cond [3], m_pos [3], m_neg [3], m_sr [3], m_sf [3];
  logic       m_any [3];

  function automatic logic [7:0] in_of(input int i);
    case (i)
      0:       return {4'b0, nz0};
      1:       return {7'b0, nz1};
      default: return nz2;
    endcase
  endfunction

  function automatic logic [7:0] clr_of(input int i);
    case (i)
      0:       return {4'b0, clr0};
      1:       return {7'b0, clr1};
      default: return clr2;
    endcase
  endfunction

  function automatic logic [7:0] acc_mask(input int i);
    logic [7:0] m;
    logic       d;
    m = '0;
    for (int c = 0; c < N_P[i]; c++) begin
      d = 1'b1;
      for (int j = 0; j < W_P[i]; j++)
        if (hist[i][S_P[i]-1+j][c] == m_cond[i][c]) d = 1'b0;
      m[c] = d;
    end
    return m;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 16; j++) hist[i][j] <= '0;
        m_cond[i] <= '0; m_pos[i] <= '0; m_neg[i] <= '0;
        m_sr[i]   <= '0; m_sf[i]  <= '0; m_any[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_cond[i] <= m_cond[i] ^ acc_mask(i);
        m_pos[i]  <= acc_mask(i) & ~m_cond[i];
        m_neg[i]  <= acc_mask(i) & m_cond[i];
        m_any[i]  <= |(m_pos[i] | m_neg[i]);
        m_sr[i]   <= STICKY ? ((m_sr[i] & ~clr_of(i)) | m_pos[i]) : 8'h00;
        m_sf[i]   <= STICKY ? ((m_sf[i] & ~clr_of(i)) | m_neg[i]) : 8'h00;
        for (int j = 15; j > 0; j--) hist[i][j] <= hist[i][j-1];
        hist[i][0] <= in_of(i);
      end
    end
  end

  logic [7:0] dc [3], dp [3], dn [3], dsr [3], dsf [3];
  logic       da [3];
  always_comb begin
    dc[0] = {4'b0, c0};  dp[0] = {4'b0, p0};  dn[0] = {4'b0, n0};
    dsr[0] = {4'b0, sr0}; dsf[0] = {4'b0, sf0}; da[0] = a0;
    dc[1] = {7'b0, c1};  dp[1] = {7'b0, p1};  dn[1] = {7'b0, n1};
    dsr[1] = {7'b0, sr1}; dsf[1] = {7'b0, sf1}; da[1] = a1;
    dc[2] = c2; dp[2] = p2; dn[2] = n2; dsr[2] = sr2; dsf[2] = sf2; da[2] = a2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; nz0 = 4'hF; nz1 = '0; nz2 = '0;
    step(); step();
    total++; if (c0 !== 4'h0) begin bad++; $display("FAIL reset_cond: got %h want 0", c0); end
    total++; if ((p0 | n0) !== 4'h0 || a0 !== 1'b0) begin bad++; $display("FAIL reset_pulses: pos %h neg %h any %b want 0", p0, n0, a0); end
    resetn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      total++; if (c0 !== ((e >= 5) ? 4'hF : 4'h0)) begin bad++; $display("FAIL release_cond e%0d: got %h want %h", e, c0, (e >= 5) ? 4'hF : 4'h0); end
      total++; if (p0 !== ((e == 5) ? 4'hF : 4'h0) || n0 !== 4'h0) begin bad++; $display("FAIL release_pulse e%0d: pos %h neg %h", e, p0, n0); end
      total++; if (a0 !== (e == 6)) begin bad++; $display("FAIL release_any e%0d: got %b want %b", e, a0, e == 6); end
    end
  endtask

  task automatic test_glitch();
    nz0 = 4'h0; resetn = 1'b0; step(); resetn = 1'b1; step(); step();
    nz0 = 4'b0001; step(); step(); nz0 = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      step();
      total++; if (c0[0] !== 1'b0 || p0[0] !== 1'b0) begin bad++; $display("FAIL glitch e%0d: cond %b pos %b want 0 0", e, c0[0], p0[0]); end
    end
    nz0 = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      step();
      total++; if (c0[0] !== (e >= 5) || p0[0] !== (e == 5)) begin bad++; $display("FAIL stable_rise e%0d: cond %b pos %b want %b %b", e, c0[0], p0[0], e >= 5, e == 5); end
    end
  endtask

  task automatic test_independence();
    nz0 = 4'b0101;
    for (int e = 0; e < 8; e++) step();
    total++; if (c0 !== 4'b0101) begin bad++; $display("FAIL indep_setup: got %b want 0101", c0); end
    nz0 = 4'b0011;
    for (int e = 1; e <= 7; e++) begin
      step();
      total++; if (p0 !== ((e == 5) ? 4'b0010 : 4'b0000) || n0 !== ((e == 5) ? 4'b0100 : 4'b0000))
        begin bad++; $display("FAIL indep_pulse e%0d: pos %b neg %b", e, p0, n0); end
      total++; if (a0 !== (e == 6)) begin bad++; $display("FAIL indep_any e%0d: got %b want %b", e, a0, e == 6); end
    end
  endtask

  task automatic test_mid_reset();
    nz0 = 4'b1011;
    for (int e = 0; e < 4; e++) step();
    total++; if (c0 !== 4'b0011 || p0 !== 4'b0000) begin bad++; $display("FAIL midrst_pre: cond %b pos %b", c0, p0); end
    #2 resetn = 1'b0;
    #1;
    total++; if (c0 !== 4'b0000 || (p0 | n0) !== 4'b0 || a0 !== 1'b0) begin bad++; $display("FAIL midrst_async: cond %b pos %b neg %b any %b", c0, p0, n0, a0); end
    nz0 = 4'b0000;
    step(); step();
    resetn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      total++; if (c0 !== 4'b0 || (p0 | n0) !== 4'b0 || a0 !== 1'b0) begin bad++; $display("FAIL midrst_post e%0d: cond %b pos %b neg %b any %b", e, c0, p0, n0, a0); end
    end
  endtask

  task automatic test_sweep();
    int la, lb;
    la = -1; lb = -1;
    nz1 = 1'b1; nz2 = 8'hFF;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (la < 0 && c1 === 1'b1) la = e;
      if (lb < 0 && c2 === 8'hFF) lb = e;
    end
    total++; if (la != 4) begin bad++; $display("FAIL sweep_lat_a: got %0d want 4", la); end
    total++; if (lb != 9) begin bad++; $display("FAIL sweep_lat_b: got %0d want 9", lb); end
  endtask

  task automatic test_random();
    resetn = 1'b0; nz0 = '0; nz1 = '0; nz2 = '0; clr0 = '0; clr1 = '0; clr2 = '0;
    step(); resetn = 1'b1;
    for (int t = 0; t < 600; t++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) nz0[b] = ~nz0[b];
      if ($urandom_range(0, 3) == 0) nz1[0] = ~nz1[0];
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) nz2[b] = ~nz2[b];
      clr0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      clr1 = 1'($urandom);
      clr2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step();
      for (int i = 0; i < 3; i++) begin
        total++; if (dc[i] !== m_cond[i]) begin bad++; $display("FAIL rand_cond i%0d t%0d: got %h want %h", i, t, dc[i], m_cond[i]); end
        total++; if (dp[i] !== m_pos[i] || dn[i] !== m_neg[i]) begin bad++; $display("FAIL rand_pulse i%0d t%0d: pos %h/%h neg %h/%h", i, t, dp[i], m_pos[i], dn[i], m_neg[i]); end
        total++; if (da[i] !== m_any[i]) begin bad++; $display("FAIL rand_any i%0d t%0d: got %b want %b", i, t, da[i], m_any[i]); end
        total++; if (dsr[i] !== m_sr[i] || dsf[i] !== m_sf[i]) begin bad++; $display("FAIL rand_sticky i%0d t%0d: rise %h/%h fall %h/%h", i, t, dsr[i], m_sr[i], dsf[i], m_sf[i]); end
      end
    end
    clr0 = '0; clr1 = '0; clr2 = '0;
  endtask

  task automatic test_sticky();
    resetn = 1'b0; nz0 = '0; clr0 = '0; step();
    resetn = 1'b1; nz0 = 4'b0001;
    for (int e = 1; e <= 5; e++) step();
    total++; if (p0[0] !== 1'b1 || sr0[0] !== 1'b0) begin bad++; $display("FAIL sticky_pre: pos %b rise %b want 1 0", p0[0], sr0[0]); end
    clr0 = 4'b0001; step();
    total++; if (sr0[0] !== STICKY) begin bad++; $display("FAIL sticky_setwins: got %b want %b", sr0[0], STICKY); end
    clr0 = 4'b0000; step();
    total++; if (sr0[0] !== STICKY) begin bad++; $display("FAIL sticky_hold: got %b want %b", sr0[0], STICKY); end
    clr0 = 4'b0001; step(); clr0 = 4'b0000;
    total++; if (sr0[0] !== 1'b0 || sf0 !== 4'b0) begin bad++; $display("FAIL sticky_clear: rise %b fall %b want 0 0", sr0[0], sf0); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_independence();
    test_mid_reset();
    test_sweep();
    test_random();
    test_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
